// File: rtl/note_seq_pkg.sv
// note_seq_pkg: shared types and constants for the note_seq pattern sequencer.
//   state_e     : sequencer FSM states (IDLE, RUN)
//   NOTE_W      : note value width
//   TICK_W_DEF  : default width of the step and gate length counters
//   pat_entry_t : one pattern memory entry, {rest, note}
package note_seq_pkg;

   localparam int NOTE_W     = 8;
   localparam int TICK_W_DEF = 24;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   typedef struct packed {
      logic              rest;   // 1 = silent step
      logic [NOTE_W-1:0] note;
   } pat_entry_t;

endpackage

// File: rtl/note_seq_if.sv
// note_seq_if: control, pattern-write and oscillator-drive signals of note_seq.
// Optional feature macro: NOTE_SEQ_GATE_EN adds gateLen_i.
//   master : drives start/stop, step length, pattern writes; observes outputs
//   slave  : the sequencer itself
// Control semantics: start_i/stop_i are level-sampled every clock, there is
// no ready; stop_i wins over start_i. wrEn_i writes one entry per cycle and is
// always accepted. All outputs are registered.
interface note_seq_if
   import note_seq_pkg::*;
#(
   parameter int STEPS  = 16,
   parameter int STEP_W = $clog2(STEPS),
   parameter int TICK_W = TICK_W_DEF
);
   logic              start_i;
   logic              stop_i;
   logic [TICK_W-1:0] stepLen_i;
`ifdef NOTE_SEQ_GATE_EN
   logic [TICK_W-1:0] gateLen_i;
`endif
   logic              wrEn_i;
   logic [STEP_W-1:0] wrAddr_i;
   logic [NOTE_W-1:0] wrNote_i;
   logic              wrRest_i;

   logic [NOTE_W-1:0] note_o;
   logic              enable_o;
   logic              nrstPhase_o;
   logic [STEP_W-1:0] step_o;
   logic              running_o;
   state_e            state_o;     // debug view of the FSM state

   modport master (
`ifdef NOTE_SEQ_GATE_EN
      output gateLen_i,
`endif
      output start_i, stop_i, stepLen_i, wrEn_i, wrAddr_i, wrNote_i, wrRest_i,
      input  note_o, enable_o, nrstPhase_o, step_o, running_o, state_o
   );

   modport slave (
`ifdef NOTE_SEQ_GATE_EN
      input  gateLen_i,
`endif
      input  start_i, stop_i, stepLen_i, wrEn_i, wrAddr_i, wrNote_i, wrRest_i,
      output note_o, enable_o, nrstPhase_o, step_o, running_o, state_o
   );

endinterface

// File: rtl/note_seq_mem.sv
// note_seq_mem: STEPS-entry register-file pattern memory.
//   clk_i, nrst_i : clock, synchronous active-low clear (all entries -> rest)
//   wr_en_i, wr_addr_i, wr_data_i : synchronous write port
//   rd_addr_i, rd_data_o          : asynchronous read port (pre-edge contents)
module note_seq_mem
   import note_seq_pkg::*;
#(
   parameter int STEPS  = 16,
   parameter int STEP_W = $clog2(STEPS)
) (
   input  logic              clk_i,
   input  logic              nrst_i,
   input  logic              wr_en_i,
   input  logic [STEP_W-1:0] wr_addr_i,
   input  pat_entry_t        wr_data_i,
   input  logic [STEP_W-1:0] rd_addr_i,
   output pat_entry_t        rd_data_o
);

   pat_entry_t mem_q [STEPS];
   pat_entry_t mem_d [STEPS];

   always_comb begin
      mem_d = mem_q;
      if (wr_en_i) begin
         mem_d[wr_addr_i] = wr_data_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!nrst_i) begin
         for (int i = 0; i < STEPS; i++) begin
            mem_q[i] <= '{rest: 1'b1, note: '0};
         end
      end else begin
         mem_q <= mem_d;
      end
   end

   // Reading the flops directly means a same-cycle write is not visible to a
   // step load; the new value appears on the next visit.
   assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/note_seq.sv
// note_seq: pattern step sequencer driving an oscillator's note/enable/phase.
// Optional feature macro: NOTE_SEQ_GATE_EN (per-step gate length).
//   clk_i  : system clock
//   nrst_i : synchronous active-low reset
//   bus    : note_seq_if.slave -- start/stop, step length, pattern write port,
//            note_o, enable_o, nrstPhase_o, step_o, running_o, state_o
module note_seq
   import note_seq_pkg::*;
#(
   parameter int STEPS  = 16,
   parameter int STEP_W = $clog2(STEPS),
   parameter int TICK_W = TICK_W_DEF
) (
   input  logic       clk_i,
   input  logic       nrst_i,
   note_seq_if.slave  bus
);

   state_e            state_q, state_d;
   logic [TICK_W-1:0] tick_q, tick_d;
   logic [STEP_W-1:0] step_q, step_d;
   logic [TICK_W-1:0] step_len_q, step_len_d;
   logic [NOTE_W-1:0] note_q, note_d;
   logic              enable_q, enable_d;
   logic              nphase_q, nphase_d;
`ifdef NOTE_SEQ_GATE_EN
   logic [TICK_W-1:0] gate_len_q, gate_len_d;
`endif

   logic              start_acc;
   logic [TICK_W-1:0] len_eff;
   logic              step_end;
   logic [STEP_W-1:0] rd_addr;
   pat_entry_t        rd_data;
   pat_entry_t        wr_data;

   assign start_acc = bus.start_i & ~bus.stop_i;
   // A zero step length would never reach its terminal count; run it as 1.
   assign len_eff   = (bus.stepLen_i == '0) ? TICK_W'(1) : bus.stepLen_i;
   assign step_end  = (tick_q == step_len_q - TICK_W'(1));
   // Address of the entry loaded on the coming edge: step 0 on (re)start,
   // otherwise the successor (power-of-two STEPS wraps for free).
   assign rd_addr   = start_acc ? '0 : step_q + 1'b1;
   assign wr_data   = '{rest: bus.wrRest_i, note: bus.wrNote_i};

   note_seq_mem #(
      .STEPS  (STEPS),
      .STEP_W (STEP_W)
   ) u_mem (
      .clk_i     (clk_i),
      .nrst_i    (nrst_i),
      .wr_en_i   (bus.wrEn_i),
      .wr_addr_i (bus.wrAddr_i),
      .wr_data_i (wr_data),
      .rd_addr_i (rd_addr),
      .rd_data_o (rd_data)
   );

   always_comb begin
      state_d    = state_q;
      tick_d     = tick_q;
      step_d     = step_q;
      step_len_d = step_len_q;
      note_d     = note_q;
      enable_d   = enable_q;
      nphase_d   = 1'b1;
`ifdef NOTE_SEQ_GATE_EN
      gate_len_d = gate_len_q;
`endif
      if (bus.stop_i) begin
         // Stopped values; note_o deliberately keeps its last value.
         state_d  = IDLE;
         tick_d   = '0;
         step_d   = '0;
         enable_d = 1'b0;
      end else if (bus.start_i) begin
         // Start from IDLE and restart in RUN behave identically.
         state_d    = RUN;
         tick_d     = '0;
         step_d     = '0;
         step_len_d = len_eff;
`ifdef NOTE_SEQ_GATE_EN
         gate_len_d = bus.gateLen_i;
`endif
         note_d     = rd_data.note;
         enable_d   = ~rd_data.rest;
         nphase_d   = 1'b0;
      end else if (state_q == RUN) begin
         if (step_end) begin
            tick_d   = '0;
            step_d   = step_q + 1'b1;
            note_d   = rd_data.note;
            enable_d = ~rd_data.rest;
            nphase_d = 1'b0;
         end else begin
            tick_d = tick_q + 1'b1;
`ifdef NOTE_SEQ_GATE_EN
            // Gate closes on the cycle the tick count reaches gate_len_q,
            // only when the gate is strictly inside the step.
            if ((gate_len_q != '0) && (gate_len_q < step_len_q) &&
                (tick_d == gate_len_q)) begin
               enable_d = 1'b0;
            end
`endif
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!nrst_i) begin
         state_q    <= IDLE;
         tick_q     <= '0;
         step_q     <= '0;
         step_len_q <= TICK_W'(1);
         note_q     <= '0;
         enable_q   <= 1'b0;
         nphase_q   <= 1'b1;
`ifdef NOTE_SEQ_GATE_EN
         gate_len_q <= '0;
`endif
      end else begin
         state_q    <= state_d;
         tick_q     <= tick_d;
         step_q     <= step_d;
         step_len_q <= step_len_d;
         note_q     <= note_d;
         enable_q   <= enable_d;
         nphase_q   <= nphase_d;
`ifdef NOTE_SEQ_GATE_EN
         gate_len_q <= gate_len_d;
`endif
      end
   end

   assign bus.note_o      = note_q;
   assign bus.enable_o    = enable_q;
   assign bus.nrstPhase_o = nphase_q;
   assign bus.step_o      = step_q;
   assign bus.running_o   = (state_q == RUN);
   assign bus.state_o     = state_q;

endmodule

// File: tb/tb_note_seq.sv
// tb_note_seq: self-checking bench for note_seq (STEPS=4), with a reference
// model based on "cycles since the current step started".
module tb_note_seq;
   import note_seq_pkg::*;

   localparam int STEPS  = 4;
   localparam int STEP_W = 2;
   localparam int TICK_W = 24;
   localparam int W      = NOTE_W + 1 + 1 + STEP_W + 1;

   logic clk;
   logic nrst;

   note_seq_if #(.STEPS(STEPS), .STEP_W(STEP_W), .TICK_W(TICK_W)) bus ();

   note_seq #(.STEPS(STEPS), .STEP_W(STEP_W), .TICK_W(TICK_W)) dut (
      .clk_i  (clk),
      .nrst_i (nrst),
      .bus    (bus)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // The model tracks whether a pattern is playing, which step it is on and
   // how many cycles that step has been showing; outputs follow from those.
   logic [8:0]  m_pat [STEPS];
   bit          m_run;
   int          m_step;
   int          m_age;
   int          m_len;
   int          m_gate;
   logic [7:0]  m_note;
   bit          m_rest;
   logic [W-1:0] exp_q[$];

   function automatic bit gate_open(input int age);
`ifdef NOTE_SEQ_GATE_EN
      if (m_gate == 0 || m_gate >= m_len) return 1'b1;
      return age < m_gate;
`else
      return 1'b1;
`endif
   endfunction

   always @(posedge clk) begin
      logic [8:0] e;
      bit en, nph;
      if (!nrst) begin
         m_run = 0; m_step = 0; m_age = 0; m_note = 8'd0; m_rest = 1;
         for (int i = 0; i < STEPS; i++) m_pat[i] = {1'b1, 8'd0};
      end else begin
         if (bus.stop_i) begin
            m_run = 0; m_step = 0; m_age = 0;
         end else if (bus.start_i) begin
            m_run = 1; m_step = 0; m_age = 0;
            m_len = (bus.stepLen_i == 0) ? 1 : int'(bus.stepLen_i);
`ifdef NOTE_SEQ_GATE_EN
            m_gate = int'(bus.gateLen_i);
`else
            m_gate = 0;
`endif
            e = m_pat[0]; m_rest = e[8]; m_note = e[7:0];
         end else if (m_run) begin
            m_age++;
            if (m_age == m_len) begin
               m_age = 0;
               m_step = (m_step + 1) % STEPS;
               e = m_pat[m_step]; m_rest = e[8]; m_note = e[7:0];
            end
         end
         if (bus.wrEn_i) m_pat[bus.wrAddr_i] = {bus.wrRest_i, bus.wrNote_i};
      end
      en  = m_run && !m_rest && gate_open(m_age);
      nph = !(m_run && m_age == 0);
      exp_q.push_back({m_note, en, nph, STEP_W'(m_run ? m_step : 0), m_run});
   end

   // ---------------- scoreboard compare ----------------
   always @(negedge clk) begin
      logic [W-1:0] x;
      if (exp_q.size() == 0) begin
         n_checks++; n_fail++;
         $display("FAIL sb_empty: got 0 entries expected 1 at %0t", $time);
      end else begin
         x = exp_q.pop_front();
         check("sb_note",    32'(bus.note_o),      32'(x[W-1 -: NOTE_W]));
         check("sb_enable",  32'(bus.enable_o),    32'(x[STEP_W+2]));
         check("sb_nphase",  32'(bus.nrstPhase_o), 32'(x[STEP_W+1]));
         check("sb_step",    32'(bus.step_o),      32'(x[STEP_W:1]));
         check("sb_running", 32'(bus.running_o),   32'(x[0]));
      end
   end

   // ---------------- driver tasks ----------------
   task automatic cyc(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic idle_inputs();
      bus.start_i = 0; bus.stop_i = 0; bus.stepLen_i = '0;
`ifdef NOTE_SEQ_GATE_EN
      bus.gateLen_i = '0;
`endif
      bus.wrEn_i = 0; bus.wrAddr_i = '0; bus.wrNote_i = '0; bus.wrRest_i = 0;
   endtask

   task automatic write_entry(input int addr, input int note, input bit rest);
      bus.wrEn_i = 1; bus.wrAddr_i = STEP_W'(addr); bus.wrNote_i = 8'(note); bus.wrRest_i = rest;
      cyc();
      bus.wrEn_i = 0;
   endtask

   task automatic start_seq(input int len, input int gate);
      bus.start_i = 1; bus.stepLen_i = TICK_W'(len);
`ifdef NOTE_SEQ_GATE_EN
      bus.gateLen_i = TICK_W'(gate);
`endif
      if (gate < 0) $display("bad gate argument");
      cyc();
      bus.start_i = 0;
   endtask

   task automatic stop_seq();
      bus.stop_i = 1; cyc(); bus.stop_i = 0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [7:0] notes [20];
      bit         ens   [20];
      int         nlow;
      idle_inputs();
      nrst = 0;

      // Reset defaults
      cyc(3);
      check("rst_note", 32'(bus.note_o), 0);
      check("rst_enable", 32'(bus.enable_o), 0);
      check("rst_nphase", 32'(bus.nrstPhase_o), 1);
      check("rst_running", 32'(bus.running_o), 0);
      nrst = 1;
      start_seq(3, 0);
      check("rst_play_rest_enable", 32'(bus.enable_o), 0);
      check("rst_play_rest_note", 32'(bus.note_o), 0);
      check("rst_play_running", 32'(bus.running_o), 1);
      check("rst_play_nphase", 32'(bus.nrstPhase_o), 0);
      stop_seq();

      // Basic playback
      write_entry(0, 60, 0);
      write_entry(1, 62, 0);
      write_entry(2, 64, 0);
      write_entry(3, 65, 1);
      start_seq(5, 0);
      nlow = 0;
      for (int k = 0; k < 20; k++) begin
         notes[k] = bus.note_o; ens[k] = bus.enable_o;
         if (!bus.nrstPhase_o) nlow++;
         cyc();
      end
      check("play_s0", 32'(notes[0]), 60);
      check("play_s0_end", 32'(notes[4]), 60);
      check("play_s1", 32'(notes[5]), 62);
      check("play_s2", 32'(notes[10]), 64);
      check("play_rest_en", 32'(ens[15]), 0);
      check("play_s2_en", 32'(ens[14]), 1);
      check("play_nphase_lows", nlow, 4);
      check("play_wrap", 32'(bus.note_o), 60);
      check("play_wrap_nphase", 32'(bus.nrstPhase_o), 0);

      // Restart mid-pattern, then start+stop together
      cyc(11);
      check("mid_step2", 32'(bus.step_o), 2);
      start_seq(5, 0);
      check("restart_step", 32'(bus.step_o), 0);
      check("restart_note", 32'(bus.note_o), 60);
      bus.stop_i = 1; bus.start_i = 1; cyc(); bus.stop_i = 0; bus.start_i = 0;
      check("prio_running", 32'(bus.running_o), 0);
      check("prio_enable", 32'(bus.enable_o), 0);
      check("prio_note_held", 32'(bus.note_o), 60);

      // Write collision on step 1
      start_seq(5, 0);
      cyc(4);
      bus.wrEn_i = 1; bus.wrAddr_i = 2'd1; bus.wrNote_i = 8'd70; bus.wrRest_i = 0;
      cyc();
      bus.wrEn_i = 0;
      check("coll_old_note", 32'(bus.note_o), 62);
      check("coll_step", 32'(bus.step_o), 1);
      cyc(20);
      check("coll_new_note", 32'(bus.note_o), 70);

      // Step length 0 acts as 1
      stop_seq();
      start_seq(0, 0);
      for (int k = 1; k < 6; k++) begin
         cyc();
         check("len0_step", 32'(bus.step_o), 32'(k % STEPS));
         check("len0_nphase", 32'(bus.nrstPhase_o), 0);
      end

      // Reset mid-step
      start_seq(5, 0);
      cyc(2);
      nrst = 0; cyc(); nrst = 1;
      check("midrst_note", 32'(bus.note_o), 0);
      check("midrst_running", 32'(bus.running_o), 0);
      check("midrst_step", 32'(bus.step_o), 0);

`ifdef NOTE_SEQ_GATE_EN
      write_entry(0, 50, 0);
      start_seq(8, 3);
      nlow = 0;
      for (int k = 0; k < 8; k++) begin
         if (bus.enable_o) nlow++;
         if (k == 2) check("gate3_last_high", 32'(bus.enable_o), 1);
         if (k == 3) check("gate3_first_low", 32'(bus.enable_o), 0);
         cyc();
      end
      check("gate3_high_cycles", nlow, 3);
      start_seq(8, 8);
      nlow = 0;
      for (int k = 0; k < 8; k++) begin
         if (bus.enable_o) nlow++;
         cyc();
      end
      check("gate8_high_cycles", nlow, 8);
      stop_seq();
`endif

      // Randomized traffic against the model
      for (int k = 0; k < 3000; k++) begin
         nrst          = ($urandom_range(0, 199) != 0);
         bus.start_i   = ($urandom_range(0, 24) == 0);
         bus.stop_i    = ($urandom_range(0, 39) == 0);
         bus.stepLen_i = TICK_W'($urandom_range(0, 6));
`ifdef NOTE_SEQ_GATE_EN
         bus.gateLen_i = TICK_W'($urandom_range(0, 7));
`endif
         bus.wrEn_i    = ($urandom_range(0, 3) == 0);
         bus.wrAddr_i  = STEP_W'($urandom_range(0, STEPS - 1));
         bus.wrNote_i  = 8'($urandom_range(0, 255));
         bus.wrRest_i  = ($urandom_range(0, 3) == 0);
         cyc();
      end
      nrst = 1;
      idle_inputs();
      cyc(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/note_seq.md
# note_seq

Pattern step sequencer that drives the oscillator's control inputs. It holds a STEPS-entry pattern of notes and rests and advances one step every `stepLen_i` clock cycles while running. At each step it presents `note_o`, `enable_o` and a one-cycle active-low phase-reset pulse, which connect directly to the oscillator's `note_i`, `enable_i` and `nrstPhase_i` ports.

## Interface
- `STEPS`, 16, pattern length; power of two, ≥2
- `STEP_W`, $clog2(STEPS), step index width
- `TICK_W`, 24, width of the step and gate length counters
- `clk_i` in 1: system clock
- `nrst_i` in 1: reset, synchronous, active-low
- `start_i` in 1: start, or restart, the pattern at step 0
- `stop_i` in 1: stop; has priority over `start_i`
- `stepLen_i` in TICK_W: clock cycles per step; sampled on an accepted start
- `wrEn_i` in 1: pattern write strobe
- `wrAddr_i` in STEP_W: pattern write address
- `wrNote_i` in 8: note value to write
- `wrRest_i` in 1: rest flag to write; 1 = silent step
- `gateLen_i` in TICK_W: gate length in cycles (present only with `NOTE_SEQ_GATE_EN`)
- `note_o` out 8: current note, to the oscillator's `note_i`
- `enable_o` out 1: oscillator enable
- `nrstPhase_o` out 1: active-low phase reset, pulsed for one cycle at each step start
- `step_o` out STEP_W: current step index
- `running_o` out 1: high while the sequencer is in RUN

## Operation
- States:
  - IDLE: the reset state.
  - RUN: the pattern is playing.
- Pattern memory: STEPS × 9 bits, organised as {rest, note}.
  - Reset sets every entry to rest=1, note=0.
  - A write is accepted whenever `wrEn_i`=1, in either state.
  - A step load reads the pre-edge contents. If a write targets the entry being loaded in the same cycle, the old data is loaded and the new data is used on the next visit.
- State transitions:
  - IDLE → RUN on `start_i`=1 && `stop_i`=0.
  - RUN → IDLE on `stop_i`=1.
  - `start_i` in RUN (without `stop_i`) restarts the pattern. It re-latches `stepLen_i` and loads step 0.
- Step length:
  - `stepLen_i` is latched into `stepLenQ`. A value of 0 is treated as 1.
  - `tickCnt` counts 0 .. stepLenQ-1.
  - At the cycle where `tickCnt`=stepLenQ-1, the next step is loaded on the following edge.
  - The step index wraps from STEPS-1 to 0.
- Step load actions, all registered:
  - `note_o`=pat[step].note
  - `enable_o`=~pat[step].rest
  - `nrstPhase_o`=0 for exactly one cycle, then 1
  - `step_o`=step
  - A rest step still pulses `nrstPhase_o`.
- Stop:
  - `enable_o`=0, `step_o`=0, `running_o`=0, `nrstPhase_o`=1.
  - `note_o` holds its last value.
- Reset values: `note_o`=0, `enable_o`=0, `nrstPhase_o`=1, `step_o`=0, `running_o`=0.
  - The state returns to IDLE and the counters clear.
  - Reset applies in any cycle, including mid-step.

## Timing
- Start latency: `start_i` sampled high at edge N → at edge N+1, `running_o`=1, `step_o`=0, `note_o`/`enable_o` show step 0, and `nrstPhase_o`=0.
- Step period: step k+1 outputs appear exactly stepLenQ cycles after step k outputs.
- Phase pulse: `nrstPhase_o` is low for one cycle per step, coincident with the first cycle of the new `note_o`.
- With stepLenQ=1, a new step loads every cycle. `nrstPhase_o` stays low continuously while running.
- Stop latency: outputs reach their stopped values one cycle after `stop_i` is sampled.

## Configuration
- `NOTE_SEQ_GATE_EN` defined:
  - The `gateLen_i` port exists and is latched alongside `stepLen_i` on an accepted start.
  - `enable_o` drops to 0 when `tickCnt` reaches gateLenQ, provided 0 < gateLenQ < stepLenQ.
  - gateLenQ=0 or gateLenQ ≥ stepLenQ gives a full-step gate.
- `NOTE_SEQ_GATE_EN` undefined:
  - No `gateLen_i` port and no gate counter logic.
  - `enable_o` is held for the whole step.

## Structure
- `note_seq_pkg` holds:
  - the state enum {IDLE, RUN}
  - `NOTE_W`=8
  - the default TICK_W
  - the pattern entry struct {rest, note}
- One sub-module, `note_seq_mem`:
  - STEPS-entry register-file pattern memory
  - one synchronous write port, one asynchronous read port
  - synchronous active-low clear
- `note_seq` contains the FSM, tick counter, step counter, gate logic and output registers.

## Test plan
- Reset defaults: hold `nrst_i`=0 for 3 cycles → all outputs at their reset values, and an immediate start plays step 0 as rest (`enable_o`=0, `note_o`=0).
- Basic playback: write pattern {60, 62, 64, rest}, STEPS=4, `stepLen_i`=5, pulse start → notes 60, 62, 64 each for 5 cycles; the rest step has `enable_o`=0; wrap to 60 after 20 cycles; `nrstPhase_o` low exactly once per step.
- Stop/start priority: assert `start_i` and `stop_i` together in RUN → IDLE next cycle, `enable_o`=0, `note_o` held. A start mid-pattern at step 2 → step 0 on the next cycle.
- Write collision: write 70 to step 1 in the cycle that step 1 loads → old note shown now, 70 shown on the next wrap.
- `stepLen_i`=0 → treated as 1, one step per cycle. Assert `nrst_i`=0 mid-step → reset values on the next cycle.
- Gate (with `NOTE_SEQ_GATE_EN`): `stepLen_i`=8, `gateLen_i`=3 → `enable_o` high for 3 cycles and low for 5. `gateLen_i`=8 → `enable_o` high for the full step.
